// File: rtl/ex_ram_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
package ex_ram_arb_pkg;

  // Largest requester count the internal index fields can address.
  localparam int unsigned PU_MAX   = 32;
  localparam int unsigned PU_IDX_W = $clog2(PU_MAX);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [PU_IDX_W-1:0] pu_idx;
  } rd_tag_t;

  typedef struct packed {
    logic                found;
    logic [PU_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [PU_MAX-1:0]   req,
                                       input logic [PU_IDX_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t    res;
    logic [31:0] idx;
    res = '0;
    for (int unsigned k = 0; k < PU_MAX; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !res.found && req[idx[PU_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[PU_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_rd_tag_pipe.sv
// Read-return tag delay line; tags emerge DEPTH cycles after they enter.
module ex_rd_tag_pipe
  import ex_ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [DEPTH];
  rd_tag_t pipe_d [DEPTH];

  // Shift every tag one stage along per cycle.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int unsigned k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Reset wipes all in-flight tags so no stale read is returned.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rst) pipe_q[k] <= '0;
      else     pipe_q[k] <= pipe_d[k];
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/ex_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among PU_COUNT requesters,
// with bounded burst locking and a tagged read-return path.
module ex_ram_arbiter
  import ex_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned PU_COUNT   = 7,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PU_COUNT-1:0]            req,
  input  logic [PU_COUNT-1:0]            lock,
  input  logic [PU_COUNT-1:0]            wr_n_rd,
  input  logic [PU_COUNT*RAM_WIDTH-1:0]  wr_data,
  input  logic [PU_COUNT*ADDR_WIDTH-1:0] addr,
  output logic [PU_COUNT-1:0]            gnt,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [RAM_WIDTH-1:0]           ram_wdata,
  input  logic [RAM_WIDTH-1:0]           ram_rdata,
  output logic [PU_COUNT-1:0]            rd_valid,
  output logic [RAM_WIDTH-1:0]           rd_data
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e            state_q, state_d;
  logic [PU_IDX_W-1:0]   owner_q, owner_d;
  logic [PU_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PU_IDX_W-1:0]   ram_idx_q, ram_idx_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [PU_MAX-1:0]     req_ext, lock_ext;
  rr_pick_t              pick;
  logic                  grant_any;
  logic [PU_IDX_W-1:0]   grant_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]  sel_wdata;
  logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
  rd_tag_t               tag_in, tag_out;

  function automatic logic [PU_IDX_W-1:0] wrap_inc(input logic [PU_IDX_W-1:0] i);
    if ((32'(i) + 32'd1) >= PU_COUNT) return '0;
    return i + 1'b1;
  endfunction

  assign req_ext  = PU_MAX'(req);
  assign lock_ext = PU_MAX'(lock);
  assign pick     = rr_pick(req_ext, rr_ptr_q, PU_COUNT);

  // Grant decode: round-robin winner in ARB, only the owner while LOCKED.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst) begin
      if (state_q == ARB) begin
        grant_any = pick.found;
        grant_idx = pick.idx;
      end else begin
        grant_any = req_ext[owner_q];
        grant_idx = owner_q;
      end
    end
    for (int unsigned i = 0; i < PU_COUNT; i++) gnt[i] = grant_any && (32'(grant_idx) == i);
  end

  // Next-state: enter a burst on a locked ARB transfer, leave on cap, unlock or idle owner.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (pick.found) begin
          rr_ptr_d = wrap_inc(pick.idx);
          if (lock_ext[pick.idx] && (BURST_MAX > 1)) begin
            state_d     = LOCKED;
            owner_d     = pick.idx;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (req_ext[owner_q] && lock_ext[owner_q] &&
            ((32'(burst_cnt_q) + 32'd1) < BURST_MAX)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          state_d     = ARB;
          burst_cnt_d = '0;
          rr_ptr_d    = wrap_inc(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Pick the granted PU's request fields off the packed buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < PU_COUNT; i++) begin
      if (gnt[i]) begin
        sel_we    = wr_n_rd[i];
        sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wr_data[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  // RAM port: strobe only on a transfer, other fields hold their last value.
  always_comb begin
    ram_en_d    = grant_any;
    ram_we_d    = grant_any ? sel_we    : ram_we_q;
    ram_addr_d  = grant_any ? sel_addr  : ram_addr_q;
    ram_wdata_d = grant_any ? sel_wdata : ram_wdata_q;
    ram_idx_d   = grant_any ? grant_idx : ram_idx_q;
  end

  // Arbitration state and registered RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Issuing PU index travels with the RAM access; only meaningful with ram_en_q.
  always_ff @(posedge clk) begin
    ram_idx_q <= ram_idx_d;
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Tag enters alongside the issued access so it lines up with ram_rdata.
  assign tag_in.valid  = ram_en_q && !ram_we_q;
  assign tag_in.pu_idx = ram_idx_q;

  ex_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Decode the returning tag into a one-hot strobe; suppressed during reset.
  always_comb begin
    for (int unsigned i = 0; i < PU_COUNT; i++)
      rd_valid[i] = tag_out.valid && !rst && (32'(tag_out.pu_idx) == i);
  end

  assign rd_data = ram_rdata;

endmodule

// File: tb/tb_ex_ram_arbiter.sv
// Bench for ex_ram_arbiter: directed tables, hand sequences, randomized traffic.
module tb_ex_ram_arbiter;
  import ex_ram_arb_pkg::*;

  localparam int P   = 7;
  localparam int W   = 16;
  localparam int A   = 8;
  localparam int RDL = 2;
  localparam int BM  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   req, lock, wr_n_rd;
  logic [P*W-1:0] wr_data;
  logic [P*A-1:0] addr;
  logic [P-1:0]   gnt;
  logic           ram_en, ram_we;
  logic [A-1:0]   ram_addr;
  logic [W-1:0]   ram_wdata, ram_rdata;
  logic [P-1:0]   rd_valid;
  logic [W-1:0]   rd_data;

  always #5 clk = ~clk;

  ex_ram_arbiter #(
    .RAM_WIDTH (W), .PU_COUNT (P), .ADDR_WIDTH (A), .RD_LATENCY (RDL), .BURST_MAX (BM)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .lock (lock), .wr_n_rd (wr_n_rd),
    .wr_data (wr_data), .addr (addr), .gnt (gnt), .ram_en (ram_en), .ram_we (ram_we),
    .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_rdata (ram_rdata),
    .rd_valid (rd_valid), .rd_data (rd_data)
  );

  // ---------------- behavioural RAM macro ----------------
  logic [W-1:0] mem [256];
  logic [W-1:0] rd_pipe [RDL];
  logic         mem_load = 1'b0;

  function automatic logic [W-1:0] memv(input int i);
    return W'((i * 40503) ^ 23130);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= mem[ram_addr];
    end
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_load) for (int i = 0; i < 256; i++) mem[i] <= memv(i);
  end
  assign ram_rdata = rd_pipe[RDL-1];

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, need 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr_in();
    req = '0; lock = '0; wr_n_rd = '0; wr_data = '0; addr = '0;
  endtask

  task automatic set_pu(input int i, input bit r, input bit lk, input bit wr,
                        input logic [A-1:0] a, input logic [W-1:0] d);
    req[i] = r; lock[i] = lk; wr_n_rd[i] = wr;
    addr[i*A +: A] = a; wr_data[i*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [P-1:0] oh(input int i);
    logic [P-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model (rule level) ----------------
  bit           m_locked;
  int           m_owner, m_cnt, m_ptr;
  logic         e_en, e_we;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_wdata;
  logic [W-1:0] ref_mem [256];

  typedef struct {
    int           due;
    int           pu;
    logic [W-1:0] data;
  } rexp_t;
  rexp_t rq[$];

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    rq.delete();
  endtask

  function automatic int model_grant(input logic [P-1:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < P; k++) if (r[(m_ptr + k) % P]) return (m_ptr + k) % P;
    return -1;
  endfunction

  task automatic model_step(input int g, input logic [P-1:0] lk);
    if (!m_locked) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % P;
        if (lk[g] && BM > 1) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end
    end else if (g >= 0 && lk[g] && m_cnt + 1 < BM) begin
      m_cnt++;
    end else begin
      m_locked = 0;
      m_ptr = (m_owner + 1) % P;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [P-1:0] req;
    logic [P-1:0] lock;
    logic [P-1:0] gnt;
  } vec_t;
  vec_t tbl [13];

  // pending request state for random traffic
  bit           pv [P];
  bit           pw [P];
  logic [A-1:0] pa [P];
  logic [W-1:0] pd [P];

  initial begin
    int   cnt [P];
    logic prev_any;

    tbl[0]  = '{7'b0010010, 7'b0000010, 7'b0000010};
    tbl[1]  = '{7'b0010010, 7'b0000010, 7'b0000010};
    tbl[2]  = '{7'b0010010, 7'b0000010, 7'b0000010};
    tbl[3]  = '{7'b0010010, 7'b0000010, 7'b0000010};
    tbl[4]  = '{7'b0010010, 7'b0000010, 7'b0010000};
    tbl[5]  = '{7'b0010010, 7'b0000010, 7'b0000010};
    tbl[6]  = '{7'b0010010, 7'b0000000, 7'b0000010};
    tbl[7]  = '{7'b0000000, 7'b0000000, 7'b0000000};
    tbl[8]  = '{7'b1000000, 7'b1000000, 7'b1000000};
    tbl[9]  = '{7'b0000001, 7'b0000000, 7'b0000000};
    tbl[10] = '{7'b0000001, 7'b0000000, 7'b0000001};
    tbl[11] = '{7'b1000001, 7'b0000000, 7'b1000000};
    tbl[12] = '{7'b1000001, 7'b0000000, 7'b0000001};

    // ---- reset state ----
    rst = 1'b1;
    clr_in();
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    req = '1;
    settle();
    chk("gnt_in_reset", gnt, '0);
    tick();
    rst = 1'b0;
    clr_in();
    settle();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    chk("rst_state", dut.state_q, ARB);

    // ---- single write from PU3 ----
    set_pu(3, 1, 0, 1, 8'h12, 16'hBEEF);
    settle();
    chk("wr_gnt", gnt, 7'b0001000);
    tick();
    clr_in();
    settle();
    chk("wr_ram_en", ram_en, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 8'h12);
    chk("wr_ram_wdata", ram_wdata, 16'hBEEF);
    chk("wr_rd_valid", rd_valid, 0);
    tick();
    settle();
    chk("wr_idle_en", ram_en, 0);
    chk("wr_hold_addr", ram_addr, 8'h12);
    chk("wr_rd_valid2", rd_valid, 0);
    tick();
    settle();
    chk("wr_rd_valid3", rd_valid, 0);
    tick();

    // ---- PU5 writes 0x1234 to 0x40, then reads it back ----
    set_pu(5, 1, 0, 1, 8'h40, 16'h1234);
    settle();
    chk("rdseq_wr_gnt", gnt, 7'b0100000);
    tick();
    clr_in();
    set_pu(5, 1, 0, 0, 8'h40, 16'h0000);
    settle();
    chk("rd_gnt", gnt, 7'b0100000);
    tick();
    clr_in();
    for (int k = 1; k <= 4; k++) begin
      settle();
      if (k == 1) begin
        chk("rd_ram_en", ram_en, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("rd_ram_addr", ram_addr, 8'h40);
      end
      chk($sformatf("rd_valid_n%0d", k), rd_valid, (k == 3) ? 7'b0100000 : 7'b0);
      if (k == 3) chk("rd_data", rd_data, 16'h1234);
      tick();
    end

    // ---- fairness: everybody requesting, no lock ----
    do_reset();
    for (int i = 0; i < P; i++) cnt[i] = 0;
    req = '1; wr_n_rd = '1;
    for (int k = 0; k < 3 * P; k++) begin
      settle();
      chk($sformatf("fair_gnt%0d", k), gnt, oh(k % P));
      for (int i = 0; i < P; i++) if (gnt[i]) cnt[i]++;
      tick();
    end
    clr_in();
    for (int i = 0; i < P; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 3);

    // ---- reset in the middle of a read ----
    do_reset();
    set_pu(2, 1, 0, 0, 8'h33, 16'h0);
    settle();
    chk("mid_rst_gnt", gnt, 7'b0000100);
    tick();
    clr_in();
    rst = 1'b1;
    settle();
    chk("mid_rst_rdv1", rd_valid, 0);
    tick();
    rst = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      settle();
      chk($sformatf("mid_rst_rdv%0d", k), rd_valid, 0);
      if (k == 2) begin
        chk("mid_rst_ram_en", ram_en, 0);
        chk("mid_rst_rr_ptr", dut.rr_ptr_q, 0);
      end
      tick();
    end

    // ---- directed table: burst cap, unlock, idle release, wrap ----
    do_reset();
    prev_any = 1'b0;
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      lock = tbl[i].lock;
      wr_n_rd = '1;
      settle();
      chk($sformatf("tbl_gnt%0d", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl_en%0d", i), ram_en, prev_any);
      if (i == 10) begin
        chk("idle_rel_state", dut.state_q, ARB);
        chk("idle_rel_ptr", dut.rr_ptr_q, 0);
      end
      prev_any = |tbl[i].gnt;
      tick();
    end
    clr_in();

    // ---- randomized traffic against the reference model ----
    mem_load = 1'b1;
    do_reset();
    mem_load = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = memv(i);
    for (int i = 0; i < P; i++) pv[i] = 0;
    model_reset();
    for (int t = 0; t < 3000; t++) begin
      bit           rnd_rst;
      int           g;
      logic [P-1:0] erv;
      logic [W-1:0] erd;
      rnd_rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < P; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = A'($urandom_range(0, 15));
          pd[i] = W'($urandom);
        end
        set_pu(i, pv[i], ($urandom_range(0, 3) != 0), pw[i], pa[i], pd[i]);
      end
      rst = rnd_rst;
      g = rnd_rst ? -1 : model_grant(req);
      erv = '0;
      erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        rexp_t e;
        e = rq.pop_front();
        if (!rnd_rst) begin erv = oh(e.pu); erd = e.data; end
      end
      settle();
      chk("rnd_gnt", gnt, oh(g));
      chk("rnd_ram_en", ram_en, e_en);
      chk("rnd_ram_we", ram_we, e_we);
      chk("rnd_ram_addr", ram_addr, e_addr);
      chk("rnd_ram_wdata", ram_wdata, e_wdata);
      chk("rnd_rd_valid", rd_valid, erv);
      if (erv != 0) chk("rnd_rd_data", rd_data, erd);
      if (rnd_rst) begin
        model_reset();
      end else begin
        e_en = (g >= 0);
        if (g >= 0) begin
          e_we = pw[g]; e_addr = pa[g]; e_wdata = pd[g];
          if (pw[g]) ref_mem[pa[g]] = pd[g];
          else rq.push_back('{cyc + 1 + RDL, g, ref_mem[pa[g]]});
          pv[g] = 0;
        end
        model_step(g, lock);
      end
      tick();
    end
    rst = 1'b0;
    clr_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
